dmem_access_ctrl: RTL and testbench
===================================

Name: dmem_access_ctrl

Overview:
- Sequences the MEM stage's access to a multi-cycle data memory with a req/ack interface.
- Reads the MEM-stage control bits, address and store data held in the EX/MEM pipeline register, then issues one memory transaction per load/store.
- Drives a stall that freezes PC, IF/ID, ID/EX and EX/MEM until the access completes, then presents load data to MEM/WB.
- Watchdog flags a memory that never acknowledges.

Parameters:
AW, 32, address width
DW, 32, data width
TIMEOUT, 16, max WAIT cycles before error; 0 disables watchdog
TW, 8, watchdog counter width; must satisfy 2^TW > TIMEOUT

Ports:
clk_i  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
M_i  in  2  MEM control from EX/MEM: bit1 MemRead, bit0 MemWrite
addr_i  in  AW  data address from EX/MEM
wdata_i  in  DW  store data from EX/MEM
stall_o  out  1  freeze PC, IF/ID, ID/EX, EX/MEM (combinational)
rdata_o  out  DW  load data to MEM/WB, valid in DONE
mem_req_o  out  1  memory request (registered)
mem_we_o  out  1  1 = write, 0 = read (registered)
mem_addr_o  out  AW  memory address (registered)
mem_wdata_o  out  DW  memory write data (registered)
mem_ack_i  in  1  memory completion, one-cycle pulse
mem_rdata_i  in  DW  read data, valid with mem_ack_i
err_o  out  1  sticky watchdog error

Behaviour:
- Interface: one clock, clk_i. Reset rst_n is asynchronous and active-low.
- Reset: state IDLE; mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, rdata_o, err_o, watchdog counter all 0.
- Reset mid-transaction drops mem_req_o immediately. The memory must tolerate an abandoned request.
- Access condition: acc = M_i[1] | M_i[0]. If both bits are set, the access is a write (MemWrite priority).
- States: IDLE, WAIT, DONE, ERR.
- IDLE:
  - If acc: stall_o = 1 combinationally.
  - At the clock edge: latch mem_addr_o <= addr_i, mem_wdata_o <= wdata_i, mem_we_o <= M_i[0], mem_req_o <= 1, counter <= 0, go WAIT.
  - If !acc: stall_o = 0, stay IDLE.
- WAIT:
  - stall_o = 1; mem_req_o held at 1; address, data and we held stable.
  - If mem_ack_i: rdata_o <= (mem_we_o ? 0 : mem_rdata_i), mem_req_o <= 0, go DONE.
  - Else if TIMEOUT != 0 and counter == TIMEOUT-1: mem_req_o <= 0, err_o <= 1, rdata_o <= 0, go ERR.
  - Else counter <= counter + 1.
  - Ack and timeout in the same cycle: ack wins, no error.
- DONE:
  - stall_o = 0 for exactly one cycle. The pipeline advances at this edge and MEM/WB captures rdata_o.
  - The same EX/MEM contents still visible this cycle are ignored (no re-issue). Next state IDLE.
- ERR: stall_o = 0 for one cycle (pipeline proceeds with rdata_o = 0), then IDLE. err_o stays 1 until reset.
- rdata_o holds its value outside DONE/ERR until the next update.
- mem_ack_i outside WAIT is ignored.
- Latency:
  - Memory acking on the first WAIT cycle: stall_o high for 2 cycles (IDLE-detect + WAIT), DONE on the 3rd cycle.
  - Each additional wait cycle adds one stall cycle.
- Back-to-back accesses: DONE -> IDLE -> the next instruction's access is detected in IDLE. Minimum 3 cycles per memory instruction.
- Non-memory instructions: zero stall.

Test Plan:
- Load, ack on first WAIT cycle: M_i=2'b10, addr_i=0x0000_0010, mem_rdata_i=0xDEAD_BEEF -> stall_o 1,1,0; mem_req_o high 1 cycle with mem_we_o=0, mem_addr_o=0x10; rdata_o=0xDEAD_BEEF in DONE.
- Store, ack after 3 wait cycles: M_i=2'b01, addr_i=0x20, wdata_i=0x1234_5678 -> mem_req_o high 4 cycles, mem_we_o=1, mem_wdata_o stable at 0x1234_5678; stall_o high 5 cycles; rdata_o=0 in DONE.
- Timeout, TIMEOUT=4, no ack -> mem_req_o high 4 cycles then drops; err_o=1 from ERR onward and stays 1 through further accesses; stall released after ERR cycle.
- Ack coincident with final watchdog cycle, TIMEOUT=4, ack in 4th WAIT cycle -> DONE, err_o stays 0.
- Back-to-back load then store, ack immediate -> two distinct transactions, 6 cycles total, no duplicate request during DONE; M_i=2'b11 -> issued as write.
- rst_n low mid-WAIT -> mem_req_o, stall_o, err_o 0 immediately (asynchronous); after release, state IDLE and a new load completes normally.

Source files
------------

// File: rtl/dmem_access_ctrl.sv
// dmem_access_ctrl
// Sequences the MEM stage's access to a multi-cycle data memory over a
// req/ack handshake. One transaction is issued per load/store. The pipeline
// stays frozen until the memory acknowledges, or until the watchdog gives up
// on a memory that never answers.

module dmem_access_ctrl #(
   parameter int AW      = 32,
   parameter int DW      = 32,
   parameter int TIMEOUT = 16,  // max WAIT cycles before error, 0 disables
   parameter int TW      = 8    // watchdog counter width, 2**TW > TIMEOUT
) (
   input  logic          clk_i,
   input  logic          rst_n,
   input  logic [1:0]    M_i,          // bit1 MemRead, bit0 MemWrite
   input  logic [AW-1:0] addr_i,
   input  logic [DW-1:0] wdata_i,
   output logic          stall_o,
   output logic [DW-1:0] rdata_o,
   output logic          mem_req_o,
   output logic          mem_we_o,
   output logic [AW-1:0] mem_addr_o,
   output logic [DW-1:0] mem_wdata_o,
   input  logic          mem_ack_i,
   input  logic [DW-1:0] mem_rdata_i,
   output logic          err_o
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_DONE,
      S_ERR
   } state_t;

   localparam bit          WD_EN   = (TIMEOUT != 0);
   localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);

   state_t        state_q, state_d;
   logic          req_q, req_d;
   logic          we_q, we_d;
   logic [AW-1:0] addr_q, addr_d;
   logic [DW-1:0] wdata_q, wdata_d;
   logic [DW-1:0] rdata_q, rdata_d;
   logic          err_q, err_d;
   logic [TW-1:0] cnt_q, cnt_d;

   logic acc;
   assign acc = M_i[1] | M_i[0];

   // Next-state, stall and register updates for the access sequencer.
   always_comb begin
      // NOTE: every signal written here gets a default first, so no path
      // leaves one unassigned and no latch is inferred.
      state_d = state_q;
      req_d   = req_q;
      we_d    = we_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      err_d   = err_q;
      cnt_d   = cnt_q;
      stall_o = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (acc) begin
               stall_o = 1'b1;
               addr_d  = addr_i;
               wdata_d = wdata_i;
               we_d    = M_i[0];  // MemWrite wins when both bits are set
               req_d   = 1'b1;
               cnt_d   = '0;
               state_d = S_WAIT;
            end
         end

         S_WAIT: begin
            stall_o = 1'b1;
            if (mem_ack_i) begin
               // An ack in the final watchdog cycle still completes cleanly.
               rdata_d = we_q ? '0 : mem_rdata_i;
               req_d   = 1'b0;
               state_d = S_DONE;
            end else if (WD_EN && (cnt_q == TO_LAST)) begin
               req_d   = 1'b0;
               err_d   = 1'b1;
               rdata_d = '0;
               state_d = S_ERR;
            end else begin
               cnt_d = cnt_q + TW'(1);
            end
         end

         // One unstalled cycle; the EX/MEM contents still visible now belong
         // to the instruction just served, so they must not be re-issued.
         S_DONE:  state_d = S_IDLE;
         S_ERR:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // State and datapath registers; reset drops the request immediately.
   always_ff @(posedge clk_i or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         req_q   <= 1'b0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         // NOTE: non-blocking assignments so every flop samples the values
         // from before this edge, independent of statement order.
         state_q <= state_d;
         req_q   <= req_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
         cnt_q   <= cnt_d;
      end
   end

   assign rdata_o     = rdata_q;
   assign mem_req_o   = req_q;
   assign mem_we_o    = we_q;
   assign mem_addr_o  = addr_q;
   assign mem_wdata_o = wdata_q;
   assign err_o       = err_q;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Testbench for dmem_access_ctrl. A transaction-level reference model derives
// the expected per-cycle behaviour from the access type and the cycle at which
// the memory acknowledges (or not), then compares against the DUT each cycle.

module tb_dmem_access_ctrl;

   localparam int AW = 32;
   localparam int DW = 32;
   localparam int T  = 4;   // watchdog limit used by this bench

   logic          clk_i = 1'b0;
   logic          rst_n;
   logic [1:0]    M_i;
   logic [AW-1:0] addr_i;
   logic [DW-1:0] wdata_i;
   logic          stall_o;
   logic [DW-1:0] rdata_o;
   logic          mem_req_o;
   logic          mem_we_o;
   logic [AW-1:0] mem_addr_o;
   logic [DW-1:0] mem_wdata_o;
   logic          mem_ack_i;
   logic [DW-1:0] mem_rdata_i;
   logic          err_o;

   int total = 0;
   int bad   = 0;

   // Reference state: last value delivered to MEM/WB and the sticky error.
   logic [DW-1:0] exp_rdata;
   logic          exp_err;

   dmem_access_ctrl #(
      .AW(AW), .DW(DW), .TIMEOUT(T), .TW(8)
   ) dut (
      .clk_i       (clk_i),
      .rst_n       (rst_n),
      .M_i         (M_i),
      .addr_i      (addr_i),
      .wdata_i     (wdata_i),
      .stall_o     (stall_o),
      .rdata_o     (rdata_o),
      .mem_req_o   (mem_req_o),
      .mem_we_o    (mem_we_o),
      .mem_addr_o  (mem_addr_o),
      .mem_wdata_o (mem_wdata_o),
      .mem_ack_i   (mem_ack_i),
      .mem_rdata_i (mem_rdata_i),
      .err_o       (err_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One memory instruction. ack_at = WAIT cycle (1-based) in which the
   // memory acks; 0 or anything beyond the watchdog limit means no ack.
   task automatic run_txn(input logic [1:0] m, input logic [31:0] a,
                          input logic [31:0] wd, input logic [31:0] rd,
                          input int ack_at);
      logic acked;
      logic exp_we;
      int   n;
      acked  = (ack_at != 0) && (ack_at <= T);
      n      = acked ? ack_at : T;
      exp_we = m[0];

      // IDLE: access detected, stall raised combinationally, no request yet.
      @(negedge clk_i);
      M_i = m; addr_i = a; wdata_i = wd; mem_ack_i = 1'b0; mem_rdata_i = $urandom;
      #1;
      check("idle_stall", stall_o, 1'b1);
      check("idle_req", mem_req_o, 1'b0);
      check("idle_rdata", rdata_o, exp_rdata);

      // WAIT cycles: request and payload held stable, pipeline frozen.
      for (int k = 1; k <= n; k++) begin
         @(negedge clk_i);
         mem_ack_i   = acked && (k == n);
         mem_rdata_i = (k == n) ? rd : $urandom;
         #1;
         check("wait_stall", stall_o, 1'b1);
         check("wait_req", mem_req_o, 1'b1);
         check("wait_we", mem_we_o, exp_we);
         check("wait_addr", mem_addr_o, a);
         check("wait_wdata", mem_wdata_o, wd);
         check("wait_err", err_o, exp_err);
      end

      if (acked) exp_rdata = exp_we ? 32'h0 : rd;
      else begin
         exp_rdata = 32'h0;
         exp_err   = 1'b1;
      end

      // DONE / ERR: one unstalled cycle, EX/MEM still shows the same access,
      // a stray ack is ignored, and no new request may appear.
      @(negedge clk_i);
      mem_ack_i = 1'($urandom_range(0, 1));
      #1;
      check("fin_stall", stall_o, 1'b0);
      check("fin_req", mem_req_o, 1'b0);
      check("fin_rdata", rdata_o, exp_rdata);
      check("fin_err", err_o, exp_err);
   endtask

   // Non-memory instruction: no stall, no request, outputs hold.
   task automatic idle_cycle();
      @(negedge clk_i);
      M_i = 2'b00; addr_i = $urandom; wdata_i = $urandom;
      mem_ack_i = 1'($urandom_range(0, 1)); mem_rdata_i = $urandom;
      #1;
      check("nop_stall", stall_o, 1'b0);
      check("nop_req", mem_req_o, 1'b0);
      check("nop_rdata", rdata_o, exp_rdata);
      check("nop_err", err_o, exp_err);
   endtask

   initial begin
      rst_n = 1'b0; M_i = 2'b00; addr_i = '0; wdata_i = '0;
      mem_ack_i = 1'b0; mem_rdata_i = '0;
      exp_rdata = 32'h0; exp_err = 1'b0;

      // Reset values.
      repeat (2) @(negedge clk_i);
      #1;
      check("rst_stall", stall_o, 1'b0);
      check("rst_req", mem_req_o, 1'b0);
      check("rst_we", mem_we_o, 1'b0);
      check("rst_addr", mem_addr_o, 32'h0);
      check("rst_wdata", mem_wdata_o, 32'h0);
      check("rst_rdata", rdata_o, 32'h0);
      check("rst_err", err_o, 1'b0);
      rst_n = 1'b1;
      idle_cycle();

      // Load acked on the first WAIT cycle.
      run_txn(2'b10, 32'h0000_0010, 32'h0, 32'hDEAD_BEEF, 1);
      idle_cycle();

      // Store acked in the 4th WAIT cycle, coinciding with the last
      // watchdog cycle: completes without error, rdata forced to 0.
      run_txn(2'b01, 32'h0000_0020, 32'h1234_5678, 32'hAAAA_5555, 4);
      idle_cycle();

      // Back-to-back load then read+write (issued as a write).
      run_txn(2'b10, 32'h0000_0100, 32'h0, 32'h0BAD_F00D, 1);
      run_txn(2'b11, 32'h0000_0104, 32'hCAFE_0001, 32'h7777_7777, 1);
      idle_cycle();

      // Memory never acks: watchdog fires, error is sticky afterwards.
      run_txn(2'b10, 32'h0000_0200, 32'h0, 32'h1111_2222, 0);
      idle_cycle();
      run_txn(2'b10, 32'h0000_0204, 32'h0, 32'h3333_4444, 2);

      // Randomized mix of accesses, wait lengths and idle gaps.
      for (int i = 0; i < 24; i++) begin
         logic [1:0] m;
         m = 2'($urandom_range(1, 3));
         run_txn(m, $urandom, $urandom, $urandom, int'($urandom_range(0, T + 1)));
         if ($urandom_range(0, 1) == 1) idle_cycle();
      end

      // Asynchronous reset in the middle of WAIT.
      @(negedge clk_i);
      M_i = 2'b10; addr_i = 32'h0000_0300; mem_ack_i = 1'b0;
      @(negedge clk_i);
      #1;
      check("pre_rst_req", mem_req_o, 1'b1);
      @(negedge clk_i);
      #2;
      rst_n = 1'b0; M_i = 2'b00;
      #1;
      check("arst_req", mem_req_o, 1'b0);
      check("arst_stall", stall_o, 1'b0);
      check("arst_err", err_o, 1'b0);
      check("arst_rdata", rdata_o, 32'h0);
      exp_err = 1'b0; exp_rdata = 32'h0;
      @(negedge clk_i);
      rst_n = 1'b1;
      idle_cycle();
      run_txn(2'b10, 32'h0000_0400, 32'h0, 32'h5A5A_A5A5, 2);
      idle_cycle();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
